// File: rtl/mvm_pkg.sv
// Shared definitions for the mvm_stream_ctrl slice.
//   MVM_K / MVM_B : default vector length and element width of the multiplier
//   JOB_WORDS     : words per job (x followed by A, row-major)
//   CNT_W         : width of the job word counter
//   mvm_ctrl_state_t : controller FSM states
package mvm_pkg;

  localparam int unsigned MVM_K     = 8;
  localparam int unsigned MVM_B     = 32;
  localparam int unsigned JOB_WORDS = MVM_K + MVM_K * MVM_K;
  localparam int unsigned CNT_W     = $clog2(JOB_WORDS + 1);

  typedef enum logic [3:0] {
    ST_FILL,
    ST_RST,
    ST_VCMD,
    ST_VEC,
    ST_MCMD,
    ST_MAT,
    ST_GO,
    ST_WAIT,
    ST_ABORT,
    ST_COLLECT,
    ST_DRAIN
  } mvm_ctrl_state_t;

endpackage

// File: rtl/mvm_result_buf.sv
// K-entry result buffer: written sequentially while the multiplier streams
// y[0..K-1], then read sequentially onto a valid/ready stream.
//   clk, reset      : clock, synchronous active-low reset
//   wr_en, wr_data  : sequential write port (one result per cycle)
//   m_valid/m_ready : output handshake; m_data = y[rd], m_last on y[K-1]
//   drain_done_c    : final output handshake happening this cycle
module mvm_result_buf
  import mvm_pkg::*;
#(
  parameter int unsigned K = MVM_K,
  parameter int unsigned B = MVM_B
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic signed [2*B-1:0] wr_data,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic signed [2*B-1:0] m_data,
  output logic                  m_last,
  output logic                  drain_done_c
);

  localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

  logic signed [2*B-1:0] mem_q [K];
  logic signed [2*B-1:0] mem_d [K];
  logic [IW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic                  valid_q, valid_d, last_q, last_d;
  logic signed [2*B-1:0] data_q, data_d;

  // Pointer/valid update; output word is looked up from the next-state
  // contents so m_data is a flop yet already shows y[0] with the first valid.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    valid_d = valid_q;

    drain_done_c = valid_q && m_ready && (rd_q == IW'(K - 1));

    if (valid_q && m_ready) begin
      if (rd_q == IW'(K - 1)) begin
        valid_d = 1'b0;
        rd_d    = '0;
      end else begin
        rd_d = rd_q + IW'(1);
      end
    end

    if (wr_en) begin
      mem_d[wr_q] = wr_data;
      if (wr_q == IW'(K - 1)) begin
        wr_d    = '0;
        valid_d = 1'b1;
        rd_d    = '0;
      end else begin
        wr_d = wr_q + IW'(1);
      end
    end

    data_d = mem_d[rd_d];
    last_d = valid_d && (rd_d == IW'(K - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(K); i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_last  = last_q;

endmodule

// File: rtl/mvm_stream_ctrl.sv
// Stream front/back end for the mvm_32_1_8_1 multiplier: buffers one job
// (x then A row-major) from s_*, replays it on the multiplier's
// load/start pins on contiguous cycles, collects the K results after done
// and drains them on m_* with backpressure.
//   clk, reset        : clock, synchronous active-low reset
//   s_valid/s_ready/s_data : job input stream
//   m_valid/m_ready/m_data/m_last : result output stream
//   err               : one-cycle pulse when done never arrives
//   mvm_*             : multiplier pin interface
module mvm_stream_ctrl
  import mvm_pkg::*;
#(
  parameter int unsigned K       = MVM_K,
  parameter int unsigned B       = MVM_B,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic signed [B-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic signed [2*B-1:0] m_data,
  output logic                  m_last,
  output logic                  err,
  output logic                  mvm_reset,
  output logic                  mvm_load_matrix,
  output logic                  mvm_load_vector,
  output logic                  mvm_start,
  output logic signed [B-1:0]   mvm_data_in,
  input  logic                  mvm_done,
  input  logic signed [2*B-1:0] mvm_data_out
);

  localparam int unsigned JW = K + K * K;
  localparam int unsigned CW = $clog2(JW + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  mvm_ctrl_state_t     state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic signed [B-1:0] job_q [JW];
  logic signed [B-1:0] job_d [JW];

  logic                s_ready_q, s_ready_d;
  logic                err_q, err_d;
  logic                mvm_reset_q, mvm_reset_d;
  logic                load_m_q, load_m_d;
  logic                load_v_q, load_v_d;
  logic                start_q, start_d;
  logic signed [B-1:0] din_q, din_d;

  logic                accept_c;
  logic                res_wr_c;
  logic                drain_done_c;

  assign accept_c = s_valid && s_ready_q;
  assign res_wr_c = (state_q == ST_COLLECT);

  // Next state; cnt runs 0..K-1 through VEC and K..JW-1 through MAT so it
  // doubles as the job-buffer read address during replay.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    job_d   = job_q;

    case (state_q)
      ST_FILL: begin
        if (accept_c) begin
          job_d[cnt_q] = s_data;
          if (cnt_q == CW'(JW - 1)) begin
            state_d = ST_RST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_RST:  state_d = ST_VCMD;
      ST_VCMD: state_d = ST_VEC;
      ST_VEC: begin
        if (cnt_q == CW'(K - 1)) state_d = ST_MCMD;
        cnt_d = cnt_q + CW'(1);
      end
      ST_MCMD: state_d = ST_MAT;
      ST_MAT: begin
        if (cnt_q == CW'(JW - 1)) begin
          state_d = ST_GO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GO: begin
        state_d = ST_WAIT;
        tmo_d   = '0;
      end
      // The abort cycle itself is the TIMEOUT-th cycle after GO.
      ST_WAIT: begin
        if (mvm_done) begin
          state_d = ST_COLLECT;
        end else if (tmo_q == TW'(TIMEOUT - 2)) begin
          state_d = ST_ABORT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_ABORT: begin
        state_d = ST_FILL;
        cnt_d   = '0;
      end
      ST_COLLECT: begin
        if (cnt_q == CW'(K - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_done_c) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase

    // Outputs decoded from the next state so they register in step with it.
    s_ready_d   = (state_d == ST_FILL);
    err_d       = (state_d == ST_ABORT);
    mvm_reset_d = (state_d == ST_RST) || (state_d == ST_ABORT);
    load_v_d    = (state_d == ST_VCMD);
    load_m_d    = (state_d == ST_MCMD);
    start_d     = (state_d == ST_GO);
    din_d       = '0;
    if ((state_d == ST_VEC) || (state_d == ST_MAT)) din_d = job_q[cnt_d];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      tmo_q       <= '0;
      s_ready_q   <= 1'b0;
      err_q       <= 1'b0;
      mvm_reset_q <= 1'b1;
      load_m_q    <= 1'b0;
      load_v_q    <= 1'b0;
      start_q     <= 1'b0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      s_ready_q   <= s_ready_d;
      err_q       <= err_d;
      mvm_reset_q <= mvm_reset_d;
      load_m_q    <= load_m_d;
      load_v_q    <= load_v_d;
      start_q     <= start_d;
      din_q       <= din_d;
    end
    // Job storage carries no reset: contents are rewritten by every FILL.
    job_q <= job_d;
  end

  mvm_result_buf #(
    .K (K),
    .B (B)
  ) u_result_buf (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (res_wr_c),
    .wr_data      (mvm_data_out),
    .m_ready      (m_ready),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .drain_done_c (drain_done_c)
  );

  assign s_ready         = s_ready_q;
  assign err             = err_q;
  assign mvm_reset       = mvm_reset_q;
  assign mvm_load_matrix = load_m_q;
  assign mvm_load_vector = load_v_q;
  assign mvm_start       = start_q;
  assign mvm_data_in     = din_q;

endmodule
